sv32_mmu_frontend: RTL and testbench



---
 rtl/sv32_mmu_frontend_pkg.sv | 38 +++
 rtl/sv32_perm_check.sv | 52 +++++
 rtl/sv32_mmu_frontend.sv | 148 ++++++++++++++
 tb/tb_sv32_mmu_frontend.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sv32_mmu_frontend_pkg.sv
// Shared Sv32 encodings: PTE flag masks, request/privilege codes, page-fault causes, FSM states.
package sv32_mmu_frontend_pkg;

  localparam logic [31:0] PTE_V = 32'h0000_0001;
  localparam logic [31:0] PTE_R = 32'h0000_0002;
  localparam logic [31:0] PTE_W = 32'h0000_0004;
  localparam logic [31:0] PTE_X = 32'h0000_0008;
  localparam logic [31:0] PTE_U = 32'h0000_0010;
  localparam logic [31:0] PTE_A = 32'h0000_0040;
  localparam logic [31:0] PTE_D = 32'h0000_0080;

  localparam logic [1:0] REQ_FETCH = 2'b00;
  localparam logic [1:0] REQ_LOAD  = 2'b01;
  localparam logic [1:0] REQ_STORE = 2'b10;
  localparam logic [1:0] REQ_RSVD  = 2'b11;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [3:0] CAUSE_NONE     = 4'd0;
  localparam logic [3:0] CAUSE_FETCH_PF = 4'd12;
  localparam logic [3:0] CAUSE_LOAD_PF  = 4'd13;
  localparam logic [3:0] CAUSE_STORE_PF = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WALK,
    ST_CHECK,
    ST_RESP,
    ST_DRAIN
  } state_e;

  function automatic logic pte_flag(input logic [31:0] pte, input logic [31:0] mask);
    return |(pte & mask);
  endfunction

endpackage

// File: rtl/sv32_perm_check.sv
// Combinational Sv32 leaf-PTE permission check; yields fault flag and page-fault cause.
module sv32_perm_check
  import sv32_mmu_frontend_pkg::*;
(
  input  logic [31:0] pte,
  input  logic [1:0]  acc_type,
  input  logic [1:0]  priv,
  input  logic        sum,
  input  logic        mxr,
  output logic        fault,
  output logic [3:0]  cause
);

  logic v, r, w, x, u, a, d;
  logic is_fetch, is_store, is_load;
  logic pte_unused;

  assign v = pte_flag(pte, PTE_V);
  assign r = pte_flag(pte, PTE_R);
  assign w = pte_flag(pte, PTE_W);
  assign x = pte_flag(pte, PTE_X);
  assign u = pte_flag(pte, PTE_U);
  assign a = pte_flag(pte, PTE_A);
  assign d = pte_flag(pte, PTE_D);

  // Reserved access type behaves as a load.
  assign is_fetch = (acc_type == REQ_FETCH);
  assign is_store = (acc_type == REQ_STORE);
  assign is_load  = (acc_type == REQ_LOAD) || (acc_type == REQ_RSVD);

  // PPN, RSW and G do not influence the permission outcome.
  assign pte_unused = ^{pte[29:8], pte[5]};

  always_comb begin
    fault = !v
         || (w && !r)
         || !a
         || (is_fetch && !x)
         || (is_load && !(r || (x && mxr)))
         || (is_store && (!w || !d))
         || ((priv == PRIV_U) && !u)
         || ((priv == PRIV_S) && u && (is_fetch || !sum))
         || (pte[31:30] != 2'b00);
    cause = CAUSE_NONE;
    if (fault) begin
      if (is_fetch)      cause = CAUSE_FETCH_PF;
      else if (is_store) cause = CAUSE_STORE_PF;
      else               cause = CAUSE_LOAD_PF;
    end
  end

endmodule

// File: rtl/sv32_mmu_frontend.sv
// Sv32 translation sequencer: bypass or walker handshake, permission check, response pulse,
// saturating fault counter. One request outstanding; req_ready only in IDLE.
module sv32_mmu_frontend
  import sv32_mmu_frontend_pkg::*;
#(
  parameter int CNT_WIDTH    = 32,
  parameter bit BYPASS_MMODE = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_vaddr,
  input  logic [1:0]           req_type,
  input  logic [1:0]           req_priv,
  input  logic                 mstatus_sum,
  input  logic                 mstatus_mxr,
  input  logic [31:0]          satp,
  output logic                 walk_valid,
  input  logic                 walk_ready,
  output logic [31:0]          walk_address,
  output logic                 walk_is_instruction,
  input  logic [31:0]          walk_pte,
  output logic                 resp_valid,
  output logic [31:0]          resp_paddr,
  output logic                 resp_fault,
  output logic [3:0]           resp_cause,
  output logic [CNT_WIDTH-1:0] fault_count
);

  state_e      state;
  logic [31:0] vaddr_q;
  logic [31:0] pte_q;
  logic [1:0]  type_q;
  logic [1:0]  priv_q;
  logic        sum_q;
  logic        mxr_q;
  logic        bypass_q;
  logic        accept;
  logic        bypass;
  logic        chk_fault;
  logic [3:0]  chk_cause;
  logic        satp_unused;

  assign accept       = req_valid && req_ready;
  assign bypass       = (BYPASS_MMODE && (req_priv == PRIV_M)) || !satp[31];
  assign satp_unused  = ^satp[30:0];
  assign walk_address = vaddr_q;

  sv32_perm_check u_perm (
    .pte      (pte_q),
    .acc_type (type_q),
    .priv     (priv_q),
    .sum      (sum_q),
    .mxr      (mxr_q),
    .fault    (chk_fault),
    .cause    (chk_cause)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state               <= ST_IDLE;
      req_ready           <= 1'b0;
      walk_valid          <= 1'b0;
      walk_is_instruction <= 1'b0;
      resp_valid          <= 1'b0;
      resp_paddr          <= '0;
      resp_fault          <= 1'b0;
      resp_cause          <= CAUSE_NONE;
      fault_count         <= '0;
      vaddr_q             <= '0;
      pte_q               <= '0;
      type_q              <= REQ_FETCH;
      priv_q              <= PRIV_U;
      sum_q               <= 1'b0;
      mxr_q               <= 1'b0;
      bypass_q            <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            vaddr_q             <= req_vaddr;
            type_q              <= req_type;
            priv_q              <= req_priv;
            sum_q               <= mstatus_sum;
            mxr_q               <= mstatus_mxr;
            bypass_q            <= bypass;
            walk_is_instruction <= (req_type == REQ_FETCH);
            req_ready           <= 1'b0;
            // Bypass also spends one cycle in CHECK so both paths share response timing.
            if (bypass) begin
              state <= ST_CHECK;
            end else begin
              state      <= ST_WALK;
              walk_valid <= 1'b1;
            end
          end
        end
        ST_WALK: begin
          if (walk_ready) begin
            pte_q      <= walk_pte;
            walk_valid <= 1'b0;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          resp_valid <= 1'b1;
          state      <= ST_RESP;
          if (bypass_q) begin
            resp_paddr <= vaddr_q;
            resp_fault <= 1'b0;
            resp_cause <= CAUSE_NONE;
          end else if (chk_fault) begin
            resp_paddr <= '0;
            resp_fault <= 1'b1;
            resp_cause <= chk_cause;
          end else begin
            resp_paddr <= {pte_q[29:10], vaddr_q[11:0]};
            resp_fault <= 1'b0;
            resp_cause <= CAUSE_NONE;
          end
        end
        ST_RESP: begin
          if (resp_fault && (fault_count != '1)) begin
            fault_count <= fault_count + CNT_WIDTH'(1);
          end
          if (bypass_q) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Walker may still show ready from the finished walk; wait it out.
          if (!walk_ready) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sv32_mmu_frontend.sv
// Directed bench for sv32_mmu_frontend: bypass, walks, permission faults, drain, reset, saturation.
module tb_sv32_mmu_frontend;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_vaddr;
  logic [1:0]    req_type;
  logic [1:0]    req_priv;
  logic          mstatus_sum;
  logic          mstatus_mxr;
  logic [31:0]   satp;
  logic          walk_valid;
  logic          walk_ready;
  logic [31:0]   walk_address;
  logic          walk_is_instruction;
  logic [31:0]   walk_pte;
  logic          resp_valid;
  logic [31:0]   resp_paddr;
  logic          resp_fault;
  logic [3:0]    resp_cause;
  logic [CW-1:0] fault_count;

  int checks = 0;
  int errors = 0;

  logic        r_got;
  int          r_lat;
  int          r_wr;
  logic        r_walk;
  logic [31:0] r_addr;
  logic        r_instr;
  logic [31:0] r_pa;
  logic        r_flt;
  logic [3:0]  r_cs;

  sv32_mmu_frontend #(.CNT_WIDTH(CW), .BYPASS_MMODE(1'b1)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_vaddr           (req_vaddr),
    .req_type            (req_type),
    .req_priv            (req_priv),
    .mstatus_sum         (mstatus_sum),
    .mstatus_mxr         (mstatus_mxr),
    .satp                (satp),
    .walk_valid          (walk_valid),
    .walk_ready          (walk_ready),
    .walk_address        (walk_address),
    .walk_is_instruction (walk_is_instruction),
    .walk_pte            (walk_pte),
    .resp_valid          (resp_valid),
    .resp_paddr          (resp_paddr),
    .resp_fault          (resp_fault),
    .resp_cause          (resp_cause),
    .fault_count         (fault_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  // One request from IDLE; walker answers after dly walk_valid cycles and drops ready next cycle.
  // Latencies are counted in cycles after the cycle in which the request was presented.
  task automatic walk_txn(input logic [31:0] va, input logic [1:0] ty, input logic [1:0] pv,
                          input logic su, input logic mx, input logic [31:0] sp,
                          input logic [31:0] pte, input int dly);
    int wcnt;
    wcnt = 0;
    r_got = 0; r_lat = 0; r_wr = 0; r_walk = 0; r_addr = '0; r_instr = 0;
    r_pa = '0; r_flt = 0; r_cs = '0;
    @(negedge clk);
    req_valid = 1; req_vaddr = va; req_type = ty; req_priv = pv;
    mstatus_sum = su; mstatus_mxr = mx; satp = sp;
    @(negedge clk);
    req_valid = 0; req_vaddr = ~va; req_type = ~ty; mstatus_sum = ~su; mstatus_mxr = ~mx; satp = ~sp;
    for (int n = 1; n <= 60 && !r_got; n++) begin
      if (resp_valid) begin
        r_got = 1; r_lat = n; r_pa = resp_paddr; r_flt = resp_fault; r_cs = resp_cause;
      end else begin
        if (walk_valid && !r_walk) begin
          r_walk = 1; r_addr = walk_address; r_instr = walk_is_instruction;
        end
        if (walk_ready) begin
          walk_ready = 0; walk_pte = 32'hFFFF_FFFF;
        end else if (walk_valid) begin
          wcnt++;
          if (wcnt == dly) begin
            walk_ready = 1; walk_pte = pte; r_wr = n;
          end
        end
        @(negedge clk);
      end
    end
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 0; req_valid = 0; req_vaddr = '0; req_type = 2'b00; req_priv = 2'b00;
    mstatus_sum = 0; mstatus_mxr = 0; satp = '0; walk_ready = 0; walk_pte = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (walk_valid !== 1'b0) begin errors++; $display("FAIL reset_walk_valid got %b want 0", walk_valid); end
    checks++; if (walk_address !== 32'h0) begin errors++; $display("FAIL reset_walk_address got %h want 0", walk_address); end
    checks++; if (walk_is_instruction !== 1'b0) begin errors++; $display("FAIL reset_walk_is_instr got %b want 0", walk_is_instruction); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if ({resp_paddr, resp_fault, resp_cause} !== 37'h0) begin errors++; $display("FAIL reset_resp got %h/%b/%0d want 0", resp_paddr, resp_fault, resp_cause); end
    checks++; if (fault_count !== 3'd0) begin errors++; $display("FAIL reset_fault_count got %0d want 0", fault_count); end
    resetn = 1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL release_req_ready got %b want 0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL first_clk_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_bypass();
    walk_txn(32'h8000_1234, 2'b01, 2'b00, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (r_got !== 1'b1) begin errors++; $display("FAIL bypass_resp got %b want 1", r_got); end
    checks++; if (r_lat != 2) begin errors++; $display("FAIL bypass_latency got %0d want 2", r_lat); end
    checks++; if (r_walk !== 1'b0) begin errors++; $display("FAIL bypass_no_walk got %b want 0", r_walk); end
    checks++; if (r_pa !== 32'h8000_1234) begin errors++; $display("FAIL bypass_paddr got %h want 80001234", r_pa); end
    checks++; if ({r_flt, r_cs} !== 5'h0) begin errors++; $display("FAIL bypass_fault got %b/%0d want 0/0", r_flt, r_cs); end
    walk_txn(32'h1234_5678, 2'b10, 2'b11, 0, 0, 32'h8000_0000, 32'h0, 1);
    checks++; if (r_walk !== 1'b0) begin errors++; $display("FAIL mmode_no_walk got %b want 0", r_walk); end
    checks++; if (r_pa !== 32'h1234_5678) begin errors++; $display("FAIL mmode_paddr got %h want 12345678", r_pa); end
    checks++; if (r_flt !== 1'b0) begin errors++; $display("FAIL mmode_fault got %b want 0", r_flt); end
  endtask

  task automatic test_walk_ok();
    walk_txn(32'h1000_0abc, 2'b01, 2'b01, 0, 0, 32'h8000_0000, 32'h2000_04CF, 5);
    checks++; if (r_got !== 1'b1) begin errors++; $display("FAIL walk_resp got %b want 1", r_got); end
    checks++; if (r_wr != 5) begin errors++; $display("FAIL walk_ready_cycle got %0d want 5", r_wr); end
    checks++; if (r_lat != 7) begin errors++; $display("FAIL walk_latency got %0d want 7", r_lat); end
    checks++; if (r_addr !== 32'h1000_0abc) begin errors++; $display("FAIL walk_address got %h want 10000abc", r_addr); end
    checks++; if (r_instr !== 1'b0) begin errors++; $display("FAIL walk_is_instr got %b want 0", r_instr); end
    checks++; if (r_pa !== 32'h8000_1abc) begin errors++; $display("FAIL walk_paddr got %h want 80001abc", r_pa); end
    checks++; if ({r_flt, r_cs} !== 5'h0) begin errors++; $display("FAIL walk_fault got %b/%0d want 0/0", r_flt, r_cs); end
    repeat (3) @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse got %b want 0", resp_valid); end
    checks++; if (resp_paddr !== 32'h8000_1abc) begin errors++; $display("FAIL resp_hold got %h want 80001abc", resp_paddr); end
  endtask

  task automatic test_store_fault();
    walk_txn(32'h1000_0abc, 2'b10, 2'b01, 0, 0, 32'h8000_0000, 32'h2000_008F, 3);
    checks++; if ({r_got, r_flt} !== 2'b11) begin errors++; $display("FAIL store_fault got %b want 1", r_flt); end
    checks++; if (r_cs !== 4'd15) begin errors++; $display("FAIL store_cause got %0d want 15", r_cs); end
    checks++; if (r_pa !== 32'h0) begin errors++; $display("FAIL store_paddr got %h want 0", r_pa); end
    checks++; if (fault_count !== 3'd1) begin errors++; $display("FAIL store_count got %0d want 1", fault_count); end
  endtask

  task automatic test_user_page();
    walk_txn(32'h1000_0abc, 2'b01, 2'b01, 0, 0, 32'h8000_0000, 32'h2000_005B, 2);
    checks++; if ({r_flt, r_cs} !== {1'b1, 4'd13}) begin errors++; $display("FAIL upage_nosum got %b/%0d want 1/13", r_flt, r_cs); end
    walk_txn(32'h1000_0abc, 2'b01, 2'b01, 1, 0, 32'h8000_0000, 32'h2000_005B, 2);
    checks++; if ({r_flt, r_cs} !== 5'h0) begin errors++; $display("FAIL upage_sum got %b/%0d want 0/0", r_flt, r_cs); end
    checks++; if (r_pa !== 32'h8000_0abc) begin errors++; $display("FAIL upage_sum_paddr got %h want 80000abc", r_pa); end
    walk_txn(32'h1000_0abc, 2'b00, 2'b01, 1, 0, 32'h8000_0000, 32'h2000_005B, 2);
    checks++; if ({r_flt, r_cs} !== {1'b1, 4'd12}) begin errors++; $display("FAIL upage_fetch got %b/%0d want 1/12", r_flt, r_cs); end
    checks++; if (r_instr !== 1'b1) begin errors++; $display("FAIL upage_fetch_instr got %b want 1", r_instr); end
    checks++; if (fault_count !== 3'd3) begin errors++; $display("FAIL upage_count got %0d want 3", fault_count); end
  endtask

  task automatic test_perm_misc();
    walk_txn(32'h1000_0abc, 2'b01, 2'b00, 0, 0, 32'h8000_0000, 32'h2000_04CF, 1);
    checks++; if (r_cs !== 4'd13) begin errors++; $display("FAIL umode_supervisor_page got %0d want 13", r_cs); end
    walk_txn(32'h1000_0abc, 2'b01, 2'b01, 0, 0, 32'h8000_0000, 32'h2000_0049, 1);
    checks++; if (r_cs !== 4'd13) begin errors++; $display("FAIL xonly_nomxr got %0d want 13", r_cs); end
    walk_txn(32'h1000_0abc, 2'b01, 2'b01, 0, 1, 32'h8000_0000, 32'h2000_0049, 1);
    checks++; if ({r_flt, r_pa} !== {1'b0, 32'h8000_0abc}) begin errors++; $display("FAIL xonly_mxr got %b/%h want 0/80000abc", r_flt, r_pa); end
    walk_txn(32'h1000_0abc, 2'b01, 2'b01, 0, 0, 32'h8000_0000, 32'h4000_04CF, 1);
    checks++; if (r_cs !== 4'd13) begin errors++; $display("FAIL ppn_high got %0d want 13", r_cs); end
    walk_txn(32'h1000_0abc, 2'b10, 2'b01, 0, 0, 32'h8000_0000, 32'h2000_00C5, 1);
    checks++; if (r_cs !== 4'd15) begin errors++; $display("FAIL w_without_r got %0d want 15", r_cs); end
    walk_txn(32'h1000_0abc, 2'b11, 2'b01, 0, 0, 32'h8000_0000, 32'h0000_0000, 1);
    checks++; if ({r_flt, r_cs} !== {1'b1, 4'd13}) begin errors++; $display("FAIL reserved_type got %b/%0d want 1/13", r_flt, r_cs); end
    checks++; if (fault_count !== 3'd7) begin errors++; $display("FAIL misc_count_saturated got %0d want 7", fault_count); end
  endtask

  task automatic test_drain();
    @(negedge clk);
    req_valid = 1; req_vaddr = 32'h1000_0abc; req_type = 2'b01; req_priv = 2'b01;
    mstatus_sum = 0; mstatus_mxr = 0; satp = 32'h8000_0000;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    walk_ready = 1; walk_pte = 32'h2000_04CF;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({resp_valid, resp_paddr} !== {1'b1, 32'h8000_1abc}) begin errors++; $display("FAIL drain_first_resp got %b/%h want 1/80001abc", resp_valid, resp_paddr); end
    req_valid = 1; req_vaddr = 32'h1000_0def;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({req_ready, walk_valid} !== 2'b00) begin errors++; $display("FAIL drain_hold%0d got rdy=%b wv=%b want 0/0", i, req_ready, walk_valid); end
    end
    walk_ready = 0;
    @(negedge clk);
    checks++; if ({req_ready, walk_valid} !== 2'b10) begin errors++; $display("FAIL drain_release got rdy=%b wv=%b want 1/0", req_ready, walk_valid); end
    @(negedge clk);
    checks++; if ({walk_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL drain_accept got wv=%b rdy=%b want 1/0", walk_valid, req_ready); end
    checks++; if (walk_address !== 32'h1000_0def) begin errors++; $display("FAIL drain_walk_address got %h want 10000def", walk_address); end
    req_valid = 0; walk_ready = 1; walk_pte = 32'h2000_04CF;
    @(negedge clk);
    walk_ready = 0; walk_pte = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if ({resp_valid, resp_paddr} !== {1'b1, 32'h8000_1def}) begin errors++; $display("FAIL drain_second_resp got %b/%h want 1/80001def", resp_valid, resp_paddr); end
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
  endtask

  task automatic test_reset_mid_walk();
    logic seen;
    seen = 0;
    @(negedge clk);
    req_valid = 1; req_vaddr = 32'h1000_0abc; req_type = 2'b01; req_priv = 2'b01; satp = 32'h8000_0000;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    checks++; if (walk_valid !== 1'b1) begin errors++; $display("FAIL midwalk_in_walk got %b want 1", walk_valid); end
    resetn = 0;
    #1;
    checks++; if ({walk_valid, req_ready, walk_address} !== 34'h0) begin errors++; $display("FAIL midwalk_async got wv=%b rdy=%b addr=%h want 0", walk_valid, req_ready, walk_address); end
    checks++; if ({resp_paddr, fault_count} !== 35'h0) begin errors++; $display("FAIL midwalk_clear got %h/%0d want 0/0", resp_paddr, fault_count); end
    walk_ready = 1; walk_pte = 32'h2000_04CF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    walk_ready = 0; resetn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midwalk_no_resp got %b want 0", seen); end
    walk_txn(32'h1000_0abc, 2'b01, 2'b01, 0, 0, 32'h8000_0000, 32'h2000_04CF, 2);
    checks++; if ({r_got, r_flt, r_pa} !== {2'b10, 32'h8000_1abc}) begin errors++; $display("FAIL midwalk_recover got %b/%b/%h want 1/0/80001abc", r_got, r_flt, r_pa); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 7; i++) walk_txn(32'h1000_0abc, 2'b01, 2'b01, 0, 0, 32'h8000_0000, 32'h0, 1);
    checks++; if (fault_count !== 3'd7) begin errors++; $display("FAIL sat_reach got %0d want 7", fault_count); end
    walk_txn(32'h1000_0abc, 2'b10, 2'b01, 0, 0, 32'h8000_0000, 32'h0, 1);
    checks++; if ({r_flt, r_cs} !== {1'b1, 4'd15}) begin errors++; $display("FAIL sat_extra_fault got %b/%0d want 1/15", r_flt, r_cs); end
    checks++; if (fault_count !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d want 7", fault_count); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_walk_ok();
    test_store_fault();
    test_user_page();
    test_perm_misc();
    test_drain();
    test_reset_mid_walk();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
